// File: rtl/hvac_pkg.sv
// Shared types and default thresholds/timings for the HVAC zone scheduler.
package hvac_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDead = 2'd2
    } state_e;

    typedef enum logic {
        ModeHeat = 1'b0,
        ModeCool = 1'b1
    } mode_e;

    localparam int unsigned DefNZones   = 4;
    localparam int unsigned DefTempW    = 5;
    localparam int unsigned DefHeatOn   = 18;
    localparam int unsigned DefHeatOff  = 20;
    localparam int unsigned DefCoolOn   = 22;
    localparam int unsigned DefCoolOff  = 21;
    localparam int unsigned DefMinRun   = 8;
    localparam int unsigned DefMaxRun   = 32;
    localparam int unsigned DefDeadTime = 4;

endpackage

// File: rtl/hvac_rr_pick.sv
// Combinational round-robin picker: first requesting zone at or after ptr_i, wrapping.
module hvac_rr_pick #(
    parameter int unsigned N_ZONES = 4,
    localparam int unsigned IdxW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic [N_ZONES-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic               valid_o,
    output logic [IdxW-1:0]    idx_o
);

    logic [IdxW:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Walk offsets from farthest to nearest so the nearest requester wins.
        for (int off = N_ZONES - 1; off >= 0; off--) begin
            cand = {1'b0, ptr_i} + (IdxW + 1)'(off);
            if (cand >= (IdxW + 1)'(N_ZONES)) begin
                cand = cand - (IdxW + 1)'(N_ZONES);
            end
            if (req_i[cand[IdxW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/hvac_zone_scheduler.sv
// Shares one heat/cool plant between zones: threshold demand, round-robin grant,
// min/max run time and an all-off dead time between grants. All outputs registered.
module hvac_zone_scheduler
    import hvac_pkg::*;
#(
    parameter int unsigned N_ZONES   = DefNZones,
    parameter int unsigned TEMP_W    = DefTempW,
    parameter int unsigned HEAT_ON   = DefHeatOn,
    parameter int unsigned HEAT_OFF  = DefHeatOff,
    parameter int unsigned COOL_ON   = DefCoolOn,
    parameter int unsigned COOL_OFF  = DefCoolOff,
    parameter int unsigned MIN_RUN   = DefMinRun,
    parameter int unsigned MAX_RUN   = DefMaxRun,
    parameter int unsigned DEAD_TIME = DefDeadTime
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [N_ZONES*TEMP_W-1:0] temperature_i,
    output logic                      heating_o,
    output logic                      cooling_o,
    output logic [N_ZONES-1:0]        zone_valve_o,
    output logic [2:0]                active_zone_o,
    output logic                      busy_o
);

    localparam int unsigned IdxW  = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam int unsigned RunW  = $clog2(MAX_RUN + 1);
    localparam int unsigned DeadW = $clog2(DEAD_TIME + 1);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [IdxW-1:0]     zone_q, zone_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [RunW-1:0]     run_cnt_q, run_cnt_d;
    logic [DeadW-1:0]    dead_cnt_q, dead_cnt_d;
    logic                heating_q, heating_d;
    logic                cooling_q, cooling_d;
    logic [N_ZONES-1:0]  valve_q, valve_d;
    logic [2:0]          active_q, active_d;
    logic                busy_q, busy_d;

    logic [N_ZONES-1:0]  heat_req, cool_req, req;
    logic [TEMP_W-1:0]   served_temp;
    logic                satisfied, pick_valid, start, run_exit;
    logic [IdxW-1:0]     pick_idx;

    always_comb begin
        heat_req    = '0;
        cool_req    = '0;
        served_temp = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            heat_req[i] = temperature_i[i*TEMP_W +: TEMP_W] <= TEMP_W'(HEAT_ON);
            cool_req[i] = temperature_i[i*TEMP_W +: TEMP_W] >= TEMP_W'(COOL_ON);
            if (zone_q == IdxW'(i)) begin
                served_temp = temperature_i[i*TEMP_W +: TEMP_W];
            end
        end
        req = heat_req | cool_req;
    end

    assign satisfied = (mode_q == ModeHeat) ? (served_temp >= TEMP_W'(HEAT_OFF))
                                            : (served_temp <= TEMP_W'(COOL_OFF));

    hvac_rr_pick #(
        .N_ZONES(N_ZONES)
    ) u_pick (
        .req_i  (req),
        .ptr_i  (rr_ptr_q),
        .valid_o(pick_valid),
        .idx_o  (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        zone_d     = zone_q;
        rr_ptr_d   = rr_ptr_q;
        run_cnt_d  = run_cnt_q;
        dead_cnt_d = dead_cnt_q;
        start      = 1'b0;
        run_exit   = 1'b0;

        unique case (state_q)
            StIdle: start = enable_i && pick_valid;
            StRun: begin
                run_cnt_d = run_cnt_q + 1'b1;
                run_exit  = !enable_i
                         || (run_cnt_q == RunW'(MAX_RUN - 1))
                         || ((run_cnt_q >= RunW'(MIN_RUN - 1)) && satisfied);
                if (run_exit) begin
                    state_d    = StDead;
                    dead_cnt_d = '0;
                    rr_ptr_d   = (zone_q == IdxW'(N_ZONES - 1)) ? '0 : zone_q + 1'b1;
                end
            end
            StDead: begin
                dead_cnt_d = dead_cnt_q + 1'b1;
                if (dead_cnt_q == DeadW'(DEAD_TIME - 1)) begin
                    state_d = StIdle;
                    // The dead-time exit edge doubles as the idle sampling edge, so a
                    // persistent requester sees exactly DEAD_TIME off cycles.
                    start   = enable_i && pick_valid;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d   = StRun;
            zone_d    = pick_idx;
            mode_d    = heat_req[pick_idx] ? ModeHeat : ModeCool;
            run_cnt_d = '0;
        end

        // Outputs are registered from the next state so they change on the grant edge.
        heating_d = (state_d == StRun) && (mode_d == ModeHeat);
        cooling_d = (state_d == StRun) && (mode_d == ModeCool);
        valve_d   = '0;
        if (state_d == StRun) begin
            valve_d[zone_d] = 1'b1;
        end
        active_d = (state_d == StRun) ? 3'(zone_d) : 3'd0;
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= ModeHeat;
            zone_q     <= '0;
            rr_ptr_q   <= '0;
            run_cnt_q  <= '0;
            dead_cnt_q <= '0;
            heating_q  <= 1'b0;
            cooling_q  <= 1'b0;
            valve_q    <= '0;
            active_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            zone_q     <= zone_d;
            rr_ptr_q   <= rr_ptr_d;
            run_cnt_q  <= run_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            heating_q  <= heating_d;
            cooling_q  <= cooling_d;
            valve_q    <= valve_d;
            active_q   <= active_d;
            busy_q     <= busy_d;
        end
    end

    assign heating_o     = heating_q;
    assign cooling_o     = cooling_q;
    assign zone_valve_o  = valve_q;
    assign active_zone_o = active_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Directed bench: grant vector table, then min/max run, round-robin, abort, reset and sweep.
module tb_hvac_zone_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [19:0] temperature = '0;
    logic        heating, cooling, busy;
    logic [3:0]  zone_valve;
    logic [2:0]  active_zone;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hvac_zone_scheduler u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .temperature_i(temperature),
        .heating_o    (heating),
        .cooling_o    (cooling),
        .zone_valve_o (zone_valve),
        .active_zone_o(active_zone),
        .busy_o       (busy)
    );

    typedef struct {
        logic [19:0] temps;
        logic        en;
        logic [9:0]  exp;   // {heating, cooling, valve[3:0], active[2:0], busy}
        string       name;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [19:0] pack(input int t0, input int t1, input int t2, input int t3);
        return {5'(t3), 5'(t2), 5'(t1), 5'(t0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [9:0] outs();
        return {heating, cooling, zone_valve, active_zone, busy};
    endfunction

    initial begin
        int n;
        int m;
        int ph;
        int t;

        vecs[0] = '{pack(20, 20, 20, 20), 1'b1, 10'b0_0_0000_000_0, "v_none"};
        vecs[1] = '{pack(20, 20, 15, 20), 1'b1, 10'b1_0_0100_010_1, "v_z2_heat"};
        vecs[2] = '{pack(25, 20, 20, 25), 1'b1, 10'b0_1_0001_000_1, "v_z0z3_cool"};
        vecs[3] = '{pack(20, 18, 20, 20), 1'b1, 10'b1_0_0010_001_1, "v_heat_edge"};
        vecs[4] = '{pack(20, 20, 20, 22), 1'b1, 10'b0_1_1000_011_1, "v_cool_edge"};
        vecs[5] = '{pack(20, 19, 21, 20), 1'b1, 10'b0_0_0000_000_0, "v_deadband"};
        vecs[6] = '{pack(20, 30, 20, 10), 1'b1, 10'b0_1_0010_001_1, "v_rr_first"};
        vecs[7] = '{pack(10, 20, 20, 20), 1'b0, 10'b0_0_0000_000_0, "v_disabled"};
        vecs[8] = '{pack(0, 20, 31, 20), 1'b1, 10'b1_0_0001_000_1, "v_extremes"};

        // Reset state
        temperature = pack(20, 20, 20, 20);
        do_reset();
        check("reset_state", 32'(outs()), 32'd0);

        // Grant table: each vector from a fresh reset, one edge later
        for (int i = 0; i < 9; i++) begin
            temperature = vecs[i].temps;
            do_reset();
            enable = vecs[i].en;
            tick();
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // Asynchronous reset mid-RUN
        temperature = pack(20, 10, 20, 20);
        do_reset();
        tick();
        tick();
        check("rst_pre", 32'(outs()), 32'(10'b1_0_0010_001_1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(outs()), 32'd0);
        temperature = pack(20, 20, 20, 20);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) tick();
        check("rst_idle", 32'(outs()), 32'd0);

        // Minimum run: satisfied at run_cnt 3, held to run_cnt 7
        temperature = pack(20, 20, 15, 20);
        do_reset();
        tick();
        check("min_grant", 32'(outs()), 32'(10'b1_0_0100_010_1));
        repeat (3) tick();
        temperature = pack(20, 20, 20, 20);
        for (int k = 4; k <= 7; k++) begin
            tick();
            check($sformatf("min_hold_%0d", k), 32'(heating), 32'd1);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("min_dead_%0d", k), 32'(outs()), 32'(10'b0_0_0000_000_1));
        end
        tick();
        check("min_idle", 32'(outs()), 32'd0);

        // Round-robin: zone 0 then zone 3
        temperature = pack(25, 20, 20, 25);
        do_reset();
        tick();
        check("rr_first", 32'(outs()), 32'(10'b0_1_0001_000_1));
        temperature = pack(21, 20, 20, 25);
        n = 0;
        m = 0;
        while (zone_valve != 4'b1000 && n < 60) begin
            tick();
            n++;
            if (zone_valve == 4'b0000) m++;
        end
        check("rr_second", 32'(outs()), 32'(10'b0_1_1000_011_1));
        check("rr_dead_len", 32'(m), 32'd4);

        // Maximum run with a persistent requester
        temperature = pack(20, 10, 20, 20);
        do_reset();
        tick();
        n = 0;
        while (heating && n < 100) begin
            n++;
            tick();
        end
        check("max_on", 32'(n), 32'd32);
        m = 0;
        while (!heating && m < 100) begin
            m++;
            tick();
        end
        check("max_off", 32'(m), 32'd4);
        check("max_regrant", 32'(outs()), 32'(10'b1_0_0010_001_1));

        // Enable abort at run_cnt 2
        temperature = pack(10, 20, 20, 20);
        do_reset();
        tick();
        tick();
        tick();
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("abort_dead_%0d", k), 32'(outs()), 32'(10'b0_0_0000_000_1));
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("abort_idle_%0d", k), 32'(outs()), 32'd0);
        end

        // Sweep with invariants
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int z = 0; z < 4; z++) begin
                ph = (c / 4 + z * 5) % 20;
                t = (ph < 10) ? 15 + ph : 25 - (ph - 10);
                temperature[z*5 +: 5] = 5'(t);
            end
            enable = (c % 97) < 90;
            tick();
            check("inv_excl", 32'(heating & cooling), 32'd0);
            check("inv_valve", 32'(heating | cooling), 32'(|zone_valve));
            check("inv_onehot", 32'($onehot0(zone_valve)), 32'd1);
            check("inv_busy", 32'((heating | cooling) & ~busy), 32'd0);
            if (zone_valve != 4'b0000) begin
                check("inv_active", 32'(zone_valve), 32'(4'b0001 << active_zone));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
